cond_ctrl_pipeline: RTL and testbench

//  Parametrised control-signal pipeline: carries a decoded control bundle plus cond/flag-write/saturate

---
 rtl/cond_ctrl_pipeline_pkg.sv | 44 ++++
 rtl/cond_ctrl_pipeline_if.sv | 51 +++++
 rtl/cond_ctrl_pipeline_cond_check.sv | 47 ++++
 rtl/cond_ctrl_pipeline.sv | 162 ++++++++++++++++
 tb/tb_cond_ctrl_pipeline.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cond_ctrl_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// cond_ctrl_pipeline_pkg
//   Shared definitions for the conditional control pipeline:
//   - ARM condition codes (EQ..LE, AL, NV) as an enum.
//   - Bit positions inside the {Q,N,Z,C,V} flag word.
//   - A small helper that checks the stall vector shape.
// -----------------------------------------------------------------------------
package cond_ctrl_pipeline_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,  // Z set
        COND_NE = 4'h1,  // Z clear
        COND_CS = 4'h2,  // C set
        COND_CC = 4'h3,  // C clear
        COND_MI = 4'h4,  // N set
        COND_PL = 4'h5,  // N clear
        COND_VS = 4'h6,  // V set
        COND_VC = 4'h7,  // V clear
        COND_HI = 4'h8,  // C set and Z clear
        COND_LS = 4'h9,  // C clear or Z set
        COND_GE = 4'hA,  // N == V
        COND_LT = 4'hB,  // N != V
        COND_GT = 4'hC,  // Z clear and N == V
        COND_LE = 4'hD,  // Z set or N != V
        COND_AL = 4'hE,  // always
        COND_NV = 4'hF   // never
    } condCode_e;

    // Bit positions in the 5-bit flag word {Q,N,Z,C,V}.
    localparam int FLAG_Q = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // A legal stall vector is a run of ones starting at bit 0 (a younger
    // stage can never advance into an older stage that is held). Such a
    // vector has no bit in common with itself plus one. The vector is
    // zero-extended to 32 bits by the caller.
    function automatic logic stallIsMonotonic(input logic [31:0] stallVec);
        return ((stallVec + 32'd1) & stallVec) == 32'd0;
    endfunction

endpackage

// File: rtl/cond_ctrl_pipeline_if.sv
// -----------------------------------------------------------------------------
// cond_ctrl_pipeline_if
//   Bundles the decoder-side inputs, hazard-unit controls, ALU flag feedback
//   and the pipeline outputs of cond_ctrl_pipeline.
//   master : decoder / hazard unit / datapath side (drives inputs)
//   slave  : the pipeline itself
//   Signals:
//     ctrl_in[CTRL_W]     decoded control bundle for stage 0
//     valid_in            ctrl_in is a real instruction
//     cond_in[4]          ARM condition field
//     flag_wr_in[2]       [1]=update N,Z  [0]=update C,V
//     sat_in              saturating op (may set Q)
//     stall[N_STAGES]     hold stage s
//     flush[N_STAGES]     load bubble into stage s
//     alu_flags[5]        {Q,N,Z,C,V} from the ALU for the condition stage
//     q_clr               clear sticky Q
//     stage_ctrl          bundle of stage s at [s*CTRL_W +: CTRL_W]
//     stage_valid         valid bit of each stage
//     cond_ex             condition stage valid and condition passes
//     flags[5]            architectural {Q,N,Z,C,V}
// -----------------------------------------------------------------------------
interface cond_ctrl_pipeline_if #(
    parameter int CTRL_W   = 24,
    parameter int N_STAGES = 4
);
    logic [CTRL_W-1:0]          ctrl_in;
    logic                       valid_in;
    logic [3:0]                 cond_in;
    logic [1:0]                 flag_wr_in;
    logic                       sat_in;
    logic [N_STAGES-1:0]        stall;
    logic [N_STAGES-1:0]        flush;
    logic [4:0]                 alu_flags;
    logic                       q_clr;
    logic [N_STAGES*CTRL_W-1:0] stage_ctrl;
    logic [N_STAGES-1:0]        stage_valid;
    logic                       cond_ex;
    logic [4:0]                 flags;

    modport master (
        output ctrl_in, valid_in, cond_in, flag_wr_in, sat_in,
        output stall, flush, alu_flags, q_clr,
        input  stage_ctrl, stage_valid, cond_ex, flags
    );

    modport slave (
        input  ctrl_in, valid_in, cond_in, flag_wr_in, sat_in,
        input  stall, flush, alu_flags, q_clr,
        output stage_ctrl, stage_valid, cond_ex, flags
    );
endinterface

// File: rtl/cond_ctrl_pipeline_cond_check.sv
// -----------------------------------------------------------------------------
// cond_ctrl_pipeline_cond_check
//   Purely combinational ARM condition evaluator.
//   Ports:
//     cond[4]  in   condition code (EQ..LE, AL, NV)
//     nzcv[4]  in   {N,Z,C,V} flags the condition is tested against
//     pass     out  1 when the condition holds
// -----------------------------------------------------------------------------
module cond_ctrl_pipeline_cond_check
    import cond_ctrl_pipeline_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic flagN;
    logic flagZ;
    logic flagC;
    logic flagV;

    assign flagN = nzcv[FLAG_N];
    assign flagZ = nzcv[FLAG_Z];
    assign flagC = nzcv[FLAG_C];
    assign flagV = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (condCode_e'(cond))
            COND_EQ: pass = flagZ;
            COND_NE: pass = !flagZ;
            COND_CS: pass = flagC;
            COND_CC: pass = !flagC;
            COND_MI: pass = flagN;
            COND_PL: pass = !flagN;
            COND_VS: pass = flagV;
            COND_VC: pass = !flagV;
            COND_HI: pass = flagC && !flagZ;
            COND_LS: pass = !flagC || flagZ;
            COND_GE: pass = (flagN == flagV);
            COND_LT: pass = (flagN != flagV);
            COND_GT: pass = !flagZ && (flagN == flagV);
            COND_LE: pass = flagZ || (flagN != flagV);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;  // NV never executes
        endcase
    end
endmodule

// File: rtl/cond_ctrl_pipeline.sv
// -----------------------------------------------------------------------------
// cond_ctrl_pipeline
//   Control-signal pipeline between the instruction decoder and the datapath.
//   Each of the N_STAGES register slices carries {valid, bundle, cond,
//   flag_wr, sat}. Every slice obeys: reset > flush > stall(hold) > load,
//   and inserts a bubble when the stage behind it is held but it is not.
//   The condition of the instruction in COND_STAGE is evaluated against the
//   architectural flags; a failing instruction has its KILL_MASK bundle bits
//   cleared as it moves into COND_STAGE+1. The {Q,N,Z,C,V} register lives
//   here; Q is sticky until q_clr or reset.
//   Ports:
//     clk    in  clock
//     reset  in  synchronous active-high reset
//     bus    cond_ctrl_pipeline_if.slave (see the interface header)
// -----------------------------------------------------------------------------
module cond_ctrl_pipeline
    import cond_ctrl_pipeline_pkg::*;
#(
    parameter int               CTRL_W     = 24,
    parameter int               N_STAGES   = 4,
    parameter int               COND_STAGE = 1,
    parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'('h00000F)
) (
    input  logic                 clk,
    input  logic                 reset,
    cond_ctrl_pipeline_if.slave  bus
);

    // Registered contents of every stage, gathered so neighbours can read them.
    logic [CTRL_W-1:0] stageCtrl   [N_STAGES];
    logic              stageValid  [N_STAGES];
    logic [3:0]        stageCond   [N_STAGES];
    logic [1:0]        stageFlagWr [N_STAGES];
    logic              stageSat    [N_STAGES];

    logic       condPass;
    logic       condEx;
    logic       flagUpdate;
    logic [4:0] flagsReg;

    // -------------------------------------------------------------------------
    // Register slices
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : gStage
            logic [CTRL_W-1:0] srcCtrl;
            logic              srcValid;
            logic [3:0]        srcCond;
            logic [1:0]        srcFlagWr;
            logic              srcSat;
            logic              upstreamHeld;

            logic [CTRL_W-1:0] ctrlReg;
            logic              validReg;
            logic [3:0]        condReg;
            logic [1:0]        flagWrReg;
            logic              satReg;

            if (gi == 0) begin : gSrcDecode
                assign srcCtrl      = bus.ctrl_in;
                assign srcValid     = bus.valid_in;
                assign srcCond      = bus.cond_in;
                assign srcFlagWr    = bus.flag_wr_in;
                assign srcSat       = bus.sat_in;
                assign upstreamHeld = 1'b0;
            end else begin : gSrcPrev
                // Only the hop out of the condition stage is gated; the
                // condition stage itself always shows the raw bundle.
                localparam bit IS_KILL_HOP = (gi == COND_STAGE + 1);

                assign srcCtrl      = (IS_KILL_HOP && !condEx)
                                      ? (stageCtrl[gi-1] & ~KILL_MASK)
                                      : stageCtrl[gi-1];
                assign srcValid     = stageValid[gi-1];
                assign srcCond      = stageCond[gi-1];
                assign srcFlagWr    = stageFlagWr[gi-1];
                assign srcSat       = stageSat[gi-1];
                assign upstreamHeld = bus.stall[gi-1];
            end

            // A bubble comes either from an explicit flush or from the stage
            // behind being held while this one is free to advance; without
            // the latter the held instruction would be duplicated.
            always_ff @(posedge clk) begin
                if (reset || bus.flush[gi] || (upstreamHeld && !bus.stall[gi])) begin
                    ctrlReg   <= '0;
                    validReg  <= 1'b0;
                    condReg   <= '0;
                    flagWrReg <= '0;
                    satReg    <= 1'b0;
                end else if (!bus.stall[gi]) begin
                    ctrlReg   <= srcCtrl;
                    validReg  <= srcValid;
                    condReg   <= srcCond;
                    flagWrReg <= srcFlagWr;
                    satReg    <= srcSat;
                end
            end

            assign stageCtrl[gi]   = ctrlReg;
            assign stageValid[gi]  = validReg;
            assign stageCond[gi]   = condReg;
            assign stageFlagWr[gi] = flagWrReg;
            assign stageSat[gi]    = satReg;

            assign bus.stage_ctrl[gi*CTRL_W +: CTRL_W] = ctrlReg;
            assign bus.stage_valid[gi]                 = validReg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Condition evaluation against the architectural flags (not alu_flags),
    // so a flag-setting instruction is seen by its successor one cycle later.
    // -------------------------------------------------------------------------
    cond_ctrl_pipeline_cond_check uCondCheck (
        .cond (stageCond[COND_STAGE]),
        .nzcv (flagsReg[3:0]),
        .pass (condPass)
    );

    assign condEx = stageValid[COND_STAGE] & condPass;

    // A held condition stage will present the same instruction again next
    // cycle, so it must not commit yet. A flush of the condition stage does
    // not block the update: the instruction already there was evaluated.
    assign flagUpdate = condEx & ~bus.stall[COND_STAGE];

    // -------------------------------------------------------------------------
    // Flag register {Q,N,Z,C,V}
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            flagsReg <= '0;
        end else begin
            if (flagUpdate && stageFlagWr[COND_STAGE][1]) begin
                flagsReg[FLAG_N] <= bus.alu_flags[FLAG_N];
                flagsReg[FLAG_Z] <= bus.alu_flags[FLAG_Z];
            end
            if (flagUpdate && stageFlagWr[COND_STAGE][0]) begin
                flagsReg[FLAG_C] <= bus.alu_flags[FLAG_C];
                flagsReg[FLAG_V] <= bus.alu_flags[FLAG_V];
            end
            // Sticky Q: a new saturation event outranks a simultaneous clear.
            if (flagUpdate && stageSat[COND_STAGE] && bus.alu_flags[FLAG_Q]) begin
                flagsReg[FLAG_Q] <= 1'b1;
            end else if (bus.q_clr) begin
                flagsReg[FLAG_Q] <= 1'b0;
            end
        end
    end

    assign bus.cond_ex = condEx;
    assign bus.flags   = flagsReg;

    // The hazard unit may only hold a contiguous run of stages from stage 0.
    stallMonotonic : assert property (
        @(posedge clk) disable iff (reset)
        stallIsMonotonic(32'(bus.stall))
    );

endmodule

// File: tb/tb_cond_ctrl_pipeline.sv
// -----------------------------------------------------------------------------
// tb_cond_ctrl_pipeline
//   Directed sequences for reset, latency, kill gating, flag writes, stall
//   bubbles and sticky Q; a condition-code vector table; then randomized
//   traffic compared against an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_cond_ctrl_pipeline;
    import cond_ctrl_pipeline_pkg::*;

    localparam int          CW = 24;
    localparam int          NS = 4;
    localparam int          CS = 1;
    localparam logic [23:0] KM = 24'h00000F;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cond_ctrl_pipeline_if #(.CTRL_W(CW), .N_STAGES(NS)) bus ();

    cond_ctrl_pipeline #(
        .CTRL_W     (CW),
        .N_STAGES   (NS),
        .COND_STAGE (CS),
        .KILL_MASK  (KM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic driveBubble();
        bus.valid_in   = 1'b0;
        bus.ctrl_in    = '0;
        bus.cond_in    = '0;
        bus.flag_wr_in = '0;
        bus.sat_in     = 1'b0;
    endtask

    task automatic driveInstr(input logic [23:0] c, input logic [3:0] cd,
                              input logic [1:0] fw, input logic s);
        bus.valid_in   = 1'b1;
        bus.ctrl_in    = c;
        bus.cond_in    = cd;
        bus.flag_wr_in = fw;
        bus.sat_in     = s;
    endtask

    // Issue one instruction, then wait until it has passed the condition stage.
    task automatic issueAndSettle(input logic [23:0] c, input logic [3:0] cd,
                                  input logic [1:0] fw, input logic s);
        driveInstr(c, cd, fw, s);
        @(negedge clk);
        driveBubble();
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model (instruction records) ----------------
    typedef struct packed {
        logic        v;
        logic [23:0] c;
        logic [3:0]  cd;
        logic [1:0]  fw;
        logic        s;
    } instr_t;

    instr_t     mPipe [NS];
    logic [4:0] mFlags;

    // ARM rule: cond[3:1] selects a base test, cond[0] inverts it (AL/NV included).
    function automatic logic condHolds(input logic [3:0] cd, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        case (cd[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c & ~z;
            3'd5:    r = (n == v);
            3'd6:    r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        return r ^ cd[0];
    endfunction

    function automatic logic modelEx();
        return mPipe[CS].v && condHolds(mPipe[CS].cd, mFlags[3:0]);
    endfunction

    task automatic modelStep(input logic rst, input logic [NS-1:0] st, input logic [NS-1:0] fl,
                             input instr_t inI, input logic [4:0] alu, input logic qc);
        instr_t nxt [NS];
        logic   ex;
        logic   commit;
        ex     = modelEx();
        commit = ex && !st[CS];
        for (int s = 0; s < NS; s++) begin
            if (rst || fl[s])               nxt[s] = '0;
            else if (st[s])                 nxt[s] = mPipe[s];
            else if (s > 0 && st[s-1])      nxt[s] = '0;
            else begin
                nxt[s] = (s == 0) ? inI : mPipe[s-1];
                if (s == CS + 1 && !ex) nxt[s].c = nxt[s].c & ~KM;
            end
        end
        if (rst) begin
            mFlags = '0;
        end else begin
            if (commit && mPipe[CS].fw[1]) mFlags[3:2] = alu[3:2];
            if (commit && mPipe[CS].fw[0]) mFlags[1:0] = alu[1:0];
            if (commit && mPipe[CS].s && alu[4]) mFlags[4] = 1'b1;
            else if (qc)                         mFlags[4] = 1'b0;
        end
        for (int s = 0; s < NS; s++) mPipe[s] = nxt[s];
    endtask

    // ---------------- condition-code table ----------------
    typedef struct {
        logic [3:0] nzcv;
        logic [3:0] cd;
        logic       expEx;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] expCtrl;
        logic [3:0]  expValid;
        instr_t      inI;
        logic        rRst;
        logic [NS-1:0] rStall;
        logic [NS-1:0] rFlush;
        logic [4:0]  rAlu;
        logic        rQc;
        int          k;

        tbl[0]  = '{4'b0100, COND_EQ, 1'b1};
        tbl[1]  = '{4'b0000, COND_EQ, 1'b0};
        tbl[2]  = '{4'b0000, COND_NE, 1'b1};
        tbl[3]  = '{4'b0010, COND_HI, 1'b1};
        tbl[4]  = '{4'b0110, COND_HI, 1'b0};
        tbl[5]  = '{4'b1001, COND_GE, 1'b1};
        tbl[6]  = '{4'b1000, COND_LT, 1'b1};
        tbl[7]  = '{4'b1000, COND_GT, 1'b0};
        tbl[8]  = '{4'b0000, COND_GT, 1'b1};
        tbl[9]  = '{4'b0100, COND_LE, 1'b1};
        tbl[10] = '{4'b0000, COND_AL, 1'b1};
        tbl[11] = '{4'b1111, COND_NV, 1'b0};
        tbl[12] = '{4'b0001, COND_VS, 1'b1};
        tbl[13] = '{4'b0000, COND_MI, 1'b0};

        reset         = 1'b1;
        driveBubble();
        bus.stall     = '0;
        bus.flush     = '0;
        bus.alu_flags = '0;
        bus.q_clr     = 1'b0;
        repeat (2) @(negedge clk);

        check("reset_valid", bus.stage_valid, 4'b0000);
        check("reset_ctrl", bus.stage_ctrl, 96'h0);
        check("reset_flags", bus.flags, 5'h00);
        check("reset_cond_ex", bus.cond_ex, 1'b0);
        reset = 1'b0;

        // Latency: stage 0 after one edge, stage 3 after four.
        driveInstr(24'hABCDEF, COND_AL, 2'b00, 1'b0);
        @(negedge clk);
        check("latency_s0", bus.stage_ctrl[23:0], 24'hABCDEF);
        driveBubble();
        repeat (3) @(negedge clk);
        check("latency_s3", bus.stage_ctrl[95:72], 24'hABCDEF);
        check("latency_s3_valid", bus.stage_valid[3], 1'b1);
        $display("seq latency done");

        // Failing EQ: killed low nibble one stage later, flags untouched.
        bus.alu_flags = 5'b01111;
        driveInstr(24'h12345F, COND_EQ, 2'b11, 1'b0);
        @(negedge clk);
        driveBubble();
        @(negedge clk);
        check("kill_cond_ex", bus.cond_ex, 1'b0);
        check("kill_s1_ungated", bus.stage_ctrl[47:24], 24'h12345F);
        @(negedge clk);
        check("kill_s2_gated", bus.stage_ctrl[71:48], 24'h123450);
        check("kill_flags", bus.flags, 5'h00);
        $display("seq kill done");

        // Flag writes.
        bus.alu_flags = 5'b01010;
        issueAndSettle(24'h000001, COND_AL, 2'b11, 1'b0);
        check("flagwr_11", bus.flags, 5'h0A);
        bus.alu_flags = 5'b00000;
        issueAndSettle(24'h000002, COND_AL, 2'b10, 1'b0);
        check("flagwr_10", bus.flags, 5'h02);
        $display("seq flag write done");

        // Stall 0011 for one cycle with a flag setter held in the condition stage.
        bus.alu_flags = 5'b01111;
        driveInstr(24'h111111, COND_AL, 2'b00, 1'b0); @(negedge clk);
        driveInstr(24'h222222, COND_AL, 2'b00, 1'b0); @(negedge clk);
        driveInstr(24'h333333, COND_AL, 2'b11, 1'b0); @(negedge clk);
        driveInstr(24'h444444, COND_AL, 2'b00, 1'b0); @(negedge clk);
        bus.stall = 4'b0011;
        driveInstr(24'h555555, COND_AL, 2'b00, 1'b0);
        @(negedge clk);
        check("stall_ctrl", bus.stage_ctrl, {24'h222222, 24'h000000, 24'h333333, 24'h444444});
        check("stall_valid", bus.stage_valid, 4'b1011);
        check("stall_no_flag_update", bus.flags, 5'h02);
        bus.stall = '0;
        driveBubble();
        @(negedge clk);
        check("unstall_ctrl", bus.stage_ctrl, {24'h000000, 24'h333333, 24'h444444, 24'h000000});
        check("unstall_valid", bus.stage_valid, 4'b0110);
        check("unstall_flag_update", bus.flags, 5'h0F);
        $display("seq stall done");

        // Sticky Q.
        bus.alu_flags = 5'b10000;
        issueAndSettle(24'h000006, COND_AL, 2'b00, 1'b1);
        check("q_set", bus.flags, 5'h1F);
        bus.alu_flags = 5'b00000;
        issueAndSettle(24'h000007, COND_AL, 2'b00, 1'b1);
        check("q_sticky", bus.flags, 5'h1F);
        bus.q_clr = 1'b1;
        @(negedge clk);
        bus.q_clr = 1'b0;
        check("q_clr", bus.flags, 5'h0F);
        bus.alu_flags = 5'b10000;
        driveInstr(24'h000008, COND_AL, 2'b00, 1'b1);
        @(negedge clk);
        driveBubble();
        @(negedge clk);
        bus.q_clr = 1'b1;
        @(negedge clk);
        bus.q_clr = 1'b0;
        check("q_set_beats_clr", bus.flags, 5'h1F);
        $display("seq sticky Q done");

        // Reset mid-flow.
        driveInstr(24'h0F0F0F, COND_AL, 2'b00, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        driveBubble();
        @(negedge clk);
        reset = 1'b0;
        check("midreset_valid", bus.stage_valid, 4'b0000);
        check("midreset_ctrl", bus.stage_ctrl, 96'h0);
        check("midreset_flags", bus.flags, 5'h00);
        $display("seq mid-flow reset done");

        // Condition table: set NZCV with an AL writer, then test the next instruction.
        for (int i = 0; i < 14; i++) begin
            bus.alu_flags = {1'b0, tbl[i].nzcv};
            driveInstr(24'h00AA00 | 24'(i), COND_AL, 2'b11, 1'b0);
            @(negedge clk);
            driveInstr(24'hBB0000 | 24'(i), tbl[i].cd, 2'b00, 1'b0);
            @(negedge clk);
            driveBubble();
            @(negedge clk);
            check($sformatf("tbl%0d_cond_ex", i), bus.cond_ex, tbl[i].expEx);
            check($sformatf("tbl%0d_flags", i), bus.flags, {1'b0, tbl[i].nzcv});
            $display("vec %0d nzcv=%b cond=%h cond_ex=%b", i, tbl[i].nzcv, tbl[i].cd, bus.cond_ex);
        end

        // Randomized traffic against the model; first cycle resets both.
        for (int i = 0; i < 400; i++) begin
            if (i > 0) begin
                for (int s = 0; s < NS; s++) begin
                    expCtrl[s*24 +: 24] = mPipe[s].c;
                    expValid[s]         = mPipe[s].v;
                end
                check($sformatf("rnd%0d_ctrl", i), bus.stage_ctrl, expCtrl);
                check($sformatf("rnd%0d_valid", i), bus.stage_valid, expValid);
                check($sformatf("rnd%0d_flags", i), bus.flags, mFlags);
                check($sformatf("rnd%0d_cond_ex", i), bus.cond_ex, modelEx());
            end
            rRst = (i == 0) || ($urandom_range(0, 49) == 0);
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NS)) : 0;
            rStall = NS'((32'd1 << k) - 32'd1);
            for (int s = 0; s < NS; s++) rFlush[s] = ($urandom_range(0, 9) == 0);
            rAlu = 5'($urandom);
            rQc  = ($urandom_range(0, 9) == 0);
            inI.v  = ($urandom_range(0, 3) != 0);
            inI.c  = 24'($urandom);
            inI.cd = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
            inI.fw = 2'($urandom);
            inI.s  = 1'($urandom);

            reset          = rRst;
            bus.stall      = rStall;
            bus.flush      = rFlush;
            bus.alu_flags  = rAlu;
            bus.q_clr      = rQc;
            bus.valid_in   = inI.v;
            bus.ctrl_in    = inI.c;
            bus.cond_in    = inI.cd;
            bus.flag_wr_in = inI.fw;
            bus.sat_in     = inI.s;
            modelStep(rRst, rStall, rFlush, inI, rAlu, rQc);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
